// File: rtl/set_sched_if.sv
// Command, engine and result signals of the set-count scheduler.
// slave is the scheduler's view; master is the view of the surrounding environment.
interface set_sched_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [23:0]      cmd_central;
    logic [11:0]      cmd_radius;
    logic [1:0]       cmd_mode;
    logic [TAG_W-1:0] cmd_tag;

    logic             set_en;
    logic [23:0]      set_central;
    logic [11:0]      set_radius;
    logic [1:0]       set_mode;
    logic             set_busy;
    logic             set_valid;
    logic [7:0]       set_candidate;

    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_candidate;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;

    modport slave (
        input  cmd_valid, cmd_central, cmd_radius, cmd_mode, cmd_tag,
        input  set_busy, set_valid, set_candidate, res_ready,
        output cmd_ready, set_en, set_central, set_radius, set_mode,
        output res_valid, res_candidate, res_tag, res_err
    );

    modport master (
        output cmd_valid, cmd_central, cmd_radius, cmd_mode, cmd_tag,
        output set_busy, set_valid, set_candidate, res_ready,
        input  cmd_ready, set_en, set_central, set_radius, set_mode,
        input  res_valid, res_candidate, res_tag, res_err
    );
endinterface

// File: rtl/set_sched.sv
// Set-count job scheduler: queues commands, issues one job at a time to the engine, returns tagged results in order.
// Latency: issue one cycle after a queued job meets an idle engine; result whenever the engine reports (66 cycles nominal).
// Backpressure: cmd_ready low while the queue is full; result held until res_ready. SET_SCHED_TIMEOUT_EN adds a 128-cycle WAIT timeout.
module set_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    set_sched_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [23:0]      central;
        logic [11:0]      radius;
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
    } job_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    job_t             mem [DEPTH];
    job_t             job;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             capture;
    logic             guard;
    logic [7:0]       res_candidate;
    logic [TAG_W-1:0] res_tag;
`ifdef SET_SCHED_TIMEOUT_EN
    logic [7:0]       tmo_cnt;
    logic             expire;
    logic             res_err;
`endif

    // Full/empty come only from registered pointers, so cmd_ready never sees a same-cycle pop.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.cmd_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{central: bus.cmd_central, radius: bus.cmd_radius,
                                     mode: bus.cmd_mode, tag: bus.cmd_tag};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
`ifdef SET_SCHED_TIMEOUT_EN
        expire    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!empty && !bus.set_busy) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // The first WAIT cycle may still see a stale set_valid from the engine's previous job.
                if (!guard && bus.set_valid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
`ifdef SET_SCHED_TIMEOUT_EN
                else if (tmo_cnt == 8'd127) begin
                    expire    = 1'b1;
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            job           <= '0;
            guard         <= 1'b0;
            res_candidate <= '0;
            res_tag       <= '0;
        end else begin
            state <= state_nxt;
            if (pop) job <= mem[rd_ptr[AW-1:0]];
            if (state == ISSUE)     guard <= 1'b1;
            else if (state == WAIT) guard <= 1'b0;
            if (capture) begin
                res_candidate <= bus.set_candidate;
                res_tag       <= job.tag;
            end
`ifdef SET_SCHED_TIMEOUT_EN
            if (expire) begin
                res_candidate <= '0;
                res_tag       <= job.tag;
            end
`endif
        end
    end

`ifdef SET_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
            res_err <= 1'b0;
        end else begin
            if (state == ISSUE)     tmo_cnt <= '0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + 8'd1;
            if (capture)     res_err <= 1'b0;
            else if (expire) res_err <= 1'b1;
        end
    end
    assign bus.res_err = res_err;
`else
    assign bus.res_err = 1'b0;
`endif

    // Job registers feed the engine directly so its parameters cannot move mid-job.
    assign bus.cmd_ready     = !full;
    assign bus.set_en        = (state == ISSUE);
    assign bus.set_central   = job.central;
    assign bus.set_radius    = job.radius;
    assign bus.set_mode      = job.mode;
    assign bus.res_valid     = (state == DONE);
    assign bus.res_candidate = res_candidate;
    assign bus.res_tag       = res_tag;
endmodule

// File: tb/tb_set_sched.sv
// Directed bench for set_sched with a behavioural set-counting engine (65 cycles from set_en to set_valid).
module tb_set_sched;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    set_sched_if #(.TAG_W(TAG_W)) bus ();
    set_sched #(.DEPTH(4), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   en_count = 0;
    int   en_cyc = 0;
    int   drift  = 0;
    int   eng_cnt = 0;
    int   en0;
    int   c0;
    logic eng_busy = 1'b0;
    logic hold_busy = 1'b0;
    logic eng_kill = 1'b0;
    logic eng_respond = 1'b1;
    logic [23:0] snap_c;
    logic [11:0] snap_r;
    logic [1:0]  snap_m;
    logic [7:0]  held_cand;
    logic [3:0]  held_tag;

    logic [23:0] jc [5] = '{24'h123456, 24'h00ABCD, 24'h0F0F0F, 24'h7FFFFF, 24'h000001};
    logic [11:0] jr [5] = '{12'h011, 12'h022, 12'h033, 12'h044, 12'h055};
    logic [1:0]  jm [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0]  jt [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
    logic [7:0]  jx [5] = '{8'h11, 8'h22, 8'h00, 8'h44, 8'h55};

    assign bus.set_busy = eng_busy | hold_busy;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model_cand(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        if (m == 2'b11) return 8'd0;
        if (c == 24'h880000 && r == 12'h330) return 8'd29;
        return r[7:0];
    endfunction

    // Engine model: also counts set_en pulses and any drift of the job parameters while busy.
    initial begin
        bus.set_valid     = 1'b0;
        bus.set_candidate = 8'd0;
        forever begin
            @(negedge clk);
            bus.set_valid = 1'b0;
            if (bus.set_en === 1'b1) begin
                en_count++;
                en_cyc = cyc;
            end
            if (eng_kill) begin
                eng_busy = 1'b0;
            end else if (eng_busy) begin
                if (bus.set_central !== snap_c || bus.set_radius !== snap_r || bus.set_mode !== snap_m) drift++;
                eng_cnt++;
                if (eng_cnt == 65) begin
                    eng_busy          = 1'b0;
                    bus.set_valid     = eng_respond;
                    bus.set_candidate = model_cand(snap_c, snap_r, snap_m);
                end
            end else if (bus.set_en === 1'b1) begin
                eng_busy = 1'b1;
                eng_cnt  = 0;
                snap_c   = bus.set_central;
                snap_r   = bus.set_radius;
                snap_m   = bus.set_mode;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m, input logic [3:0] t);
        int n = 0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_central = c;
        bus.cmd_radius  = r;
        bus.cmd_mode    = m;
        bus.cmd_tag     = t;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_en(input string tag, input int budget);
        int n = 0;
        while (bus.set_en !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.set_en), 32'd1);
    endtask

    task automatic wait_res(input string tag, input int budget);
        int n = 0;
        while (bus.res_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.res_valid), 32'd1);
    endtask

    task automatic ack();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        eng_kill = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        eng_kill = 1'b0;
    endtask

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_central = '0;
        bus.cmd_radius  = '0;
        bus.cmd_mode    = '0;
        bus.cmd_tag     = '0;
        bus.res_ready   = 1'b0;

        // Reset values, sampled while reset is held
        eng_kill = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_set_en", 32'(bus.set_en), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_err", 32'(bus.res_err), 32'd0);
        chk("rst_res_candidate", 32'(bus.res_candidate), 32'd0);
        chk("rst_res_tag", 32'(bus.res_tag), 32'd0);
        chk("rst_set_central", 32'(bus.set_central), 32'd0);
        chk("rst_set_mode", 32'(bus.set_mode), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        eng_kill = 1'b0;

        // Reference job: only the low 24 bits of the reference central value fit the port
        en0 = en_count;
        push(24'h880000, 12'h330, 2'd0, 4'd5);
        wait_en("ref_issue", 5);
        wait_res("ref_res_valid", 100);
        chk("ref_latency", 32'(cyc - en_cyc), 32'd66);
        chk("ref_candidate", 32'(bus.res_candidate), 32'd29);
        chk("ref_tag", 32'(bus.res_tag), 32'd5);
        chk("ref_err", 32'(bus.res_err), 32'd0);
        chk("ref_one_set_en", 32'(en_count - en0), 32'd1);
        ack();
        chk("ref_released", 32'(bus.res_valid), 32'd0);

        // Fill the queue while the engine reports busy
        hold_busy = 1'b1;
        en0 = en_count;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid   = 1'b1;
            bus.cmd_central = jc[i];
            bus.cmd_radius  = jr[i];
            bus.cmd_mode    = jm[i];
            bus.cmd_tag     = jt[i];
            chk("fill_ready", 32'(bus.cmd_ready), 32'(i < 4));
            if (i < 4) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("full_still_blocked", 32'(bus.cmd_ready), 32'd0);
        chk("no_issue_while_busy", 32'(en_count - en0), 32'd0);
        hold_busy = 1'b0;
        @(negedge clk);
        chk("first_pop_issue", 32'(bus.set_en), 32'd1);
        chk("ready_after_pop", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("full_again_after_5th", 32'(bus.cmd_ready), 32'd0);

        for (int i = 0; i < 5; i++) begin
            wait_res("q_res_valid", 120);
            chk("q_candidate", 32'(bus.res_candidate), 32'(jx[i]));
            chk("q_tag", 32'(bus.res_tag), 32'(jt[i]));
            chk("q_err", 32'(bus.res_err), 32'd0);
            chk("q_mode_fwd", 32'(bus.set_mode), 32'(jm[i]));
            if (i == 0) begin
                held_cand = bus.res_candidate;
                held_tag  = bus.res_tag;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    chk("hold_valid", 32'(bus.res_valid), 32'd1);
                    chk("hold_candidate", 32'(bus.res_candidate), 32'(held_cand));
                    chk("hold_tag", 32'(bus.res_tag), 32'(held_tag));
                end
                chk("hold_no_set_en", 32'(en_count - en0), 32'd1);
            end
            ack();
            if (i < 4) wait_en("q_next_issue", 3);
        end
        chk("q_set_en_total", 32'(en_count - en0), 32'd5);
        chk("q_param_drift", 32'(drift), 32'd0);

        // Reset in WAIT with two commands queued
        push(24'h111111, 12'h0A0, 2'd0, 4'd7);
        push(24'h111112, 12'h0A1, 2'd1, 4'd8);
        push(24'h111113, 12'h0A2, 2'd2, 4'd9);
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", 32'(eng_busy), 32'd1);
        rst      = 1'b0;
        eng_kill = 1'b1;
        @(negedge clk);
        chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("mid_rst_set_radius", 32'(bus.set_radius), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        eng_kill = 1'b0;
        en0 = en_count;
        repeat (20) @(negedge clk);
        chk("post_rst_queue_empty", 32'(en_count - en0), 32'd0);
        hold_busy = 1'b1;
        push(24'h222222, 12'h066, 2'd2, 4'd10);
        repeat (8) @(negedge clk);
        chk("post_rst_waits_busy", 32'(en_count - en0), 32'd0);
        hold_busy = 1'b0;
        wait_en("post_rst_issue", 3);
        wait_res("post_rst_res_valid", 100);
        chk("post_rst_candidate", 32'(bus.res_candidate), 32'h66);
        chk("post_rst_tag", 32'(bus.res_tag), 32'd10);
        ack();

        // Engine that never answers
        eng_respond = 1'b0;
        push(24'h333333, 12'h077, 2'd1, 4'd11);
        wait_en("silent_issue", 3);
        c0 = en_cyc;
`ifdef SET_SCHED_TIMEOUT_EN
        wait_res("tmo_res_valid", 200);
        chk("tmo_latency", 32'(cyc - c0), 32'd129);
        chk("tmo_err", 32'(bus.res_err), 32'd1);
        chk("tmo_candidate", 32'(bus.res_candidate), 32'd0);
        chk("tmo_tag", 32'(bus.res_tag), 32'd11);
        ack();
        chk("tmo_released", 32'(bus.res_valid), 32'd0);
`else
        repeat (200) @(negedge clk);
        chk("wait_forever_valid", 32'(bus.res_valid), 32'd0);
        chk("wait_forever_err", 32'(bus.res_err), 32'd0);
        do_reset();
        chk("recover_cmd_ready", 32'(bus.cmd_ready), 32'd1);
`endif
        eng_respond = 1'b1;
        chk("final_param_drift", 32'(drift), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
